// File: rtl/ic_axi_bridge.sv
// Memory-port (req/gnt/recv/ack) to AXI4-Lite master bridge, one outstanding transaction.
// Optional request check enabled by defining IC_AXI_BRIDGE_ALIGN_CHECK_EN.
module ic_axi_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'h0FFF_FFFF,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising g_clk edge where valid && ready
  // (req && gnt, recv && ack on the memory side). Valids are registered, never
  // depend on the matching ready, and stay high until their transfer completes.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        wen_q;
  logic [31:0] axi_addr;
  logic        aw_fin;
  logic        w_fin;
  logic        unused_resp;

  // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign unused_resp = ^{m_bresp[0], m_rresp[0], wen_q};

`ifdef IC_AXI_BRIDGE_ALIGN_CHECK_EN
  logic req_bad;
  assign req_bad = (mem_addr[1:0] != 2'b00) || (mem_wen && (mem_strb == 4'b0000));
`endif

  assign axi_addr  = (addr_q & ADDR_MASK) | ADDR_BASE;
  assign m_awaddr  = axi_addr;
  assign m_araddr  = axi_addr;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = strb_q;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign mem_gnt   = (state == IDLE);
  assign dbg_state = state;

  // A channel is finished once its valid has dropped or completes this edge.
  assign aw_fin = !m_awvalid || m_awready;
  assign w_fin  = !m_wvalid || m_wready;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      strb_q    <= 4'h0;
      wen_q     <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      mem_recv  <= 1'b0;
      mem_error <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            strb_q  <= mem_strb;
            wen_q   <= mem_wen;
`ifdef IC_AXI_BRIDGE_ALIGN_CHECK_EN
            if (req_bad) begin
              state     <= RSP;
              mem_recv  <= 1'b1;
              mem_error <= 1'b1;
              mem_rdata <= 32'h0;
            end else
`endif
            if (mem_wen) begin
              state     <= WR_AW_W;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
            end else begin
              state     <= RD_AR;
              m_arvalid <= 1'b1;
            end
          end
        end
        WR_AW_W: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            state    <= WR_B;
            m_bready <= 1'b1;
          end
        end
        WR_B: begin
          if (m_bvalid) begin
            state     <= RSP;
            m_bready  <= 1'b0;
            mem_recv  <= 1'b1;
            mem_error <= m_bresp[1];
            mem_rdata <= 32'h0;
          end
        end
        RD_AR: begin
          if (m_arready) begin
            state     <= RD_R;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
          end
        end
        RD_R: begin
          if (m_rvalid) begin
            state     <= RSP;
            m_rready  <= 1'b0;
            mem_recv  <= 1'b1;
            mem_error <= m_rresp[1];
            mem_rdata <= m_rdata;
          end
        end
        RSP: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_recv  <= 1'b0;
            mem_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_axi_bridge.sv
// Directed bench for ic_axi_bridge: testbench plays both the interconnect and the AXI4-Lite slave.
module tb_ic_axi_bridge;
  logic        g_clk;
  logic        g_resetn;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid;
  logic        m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid;
  logic        m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int aw_hs  = 0;
  int w_hs   = 0;
  int ar_hs  = 0;

  ic_axi_bridge dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
    .mem_rdata(mem_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awprot(m_awprot), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_bresp(m_bresp), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .dbg_state(dbg_state)
  );

  // clock / reset
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // handshake counters, sampled at the active edge
  always @(posedge g_clk) begin
    if (m_awvalid && m_awready) aw_hs++;
    if (m_wvalid && m_wready)   w_hs++;
    if (m_arvalid && m_arready) ar_hs++;
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'h0; mem_wdata = 32'h0;
    mem_addr = 32'h0; mem_ack = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
  endtask

  task automatic test_reset();
    g_resetn = 1'b1;
    idle_inputs();
    #2 g_resetn = 1'b0;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_recv, mem_error} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000",
        {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_recv, mem_error});
    end
    checks++;
    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", mem_rdata); end
    checks++;
    if (mem_gnt !== 1'b1 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_gnt_state got %b/%0d exp 1/0", mem_gnt, dbg_state);
    end
    checks++;
    if (m_awprot !== 3'b000 || m_arprot !== 3'b000 || m_awaddr !== 32'h0) begin
      errors++; $display("FAIL reset_prot_addr got %b %b %h exp 000 000 0", m_awprot, m_arprot, m_awaddr);
    end
    repeat (2) @(posedge g_clk);
    @(negedge g_clk) g_resetn = 1'b1;
    step();
  endtask

  task automatic test_read();
    int ar0;
    ar0 = ar_hs;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h4000_0010;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
    step(); // edge N
    mem_req = 1'b0;
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_0010 || mem_gnt !== 1'b0) begin
      errors++; $display("FAIL read_ar got v=%b a=%h g=%b exp v=1 a=00000010 g=0", m_arvalid, m_araddr, mem_gnt);
    end
    step(); // N+1: AR handshake
    checks++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1 || mem_recv !== 1'b0) begin
      errors++; $display("FAIL read_r_phase got arv=%b rr=%b recv=%b exp 0 1 0", m_arvalid, m_rready, mem_recv);
    end
    step(); // N+2: R handshake, recv visible in N+3
    checks++;
    if (mem_recv !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF || mem_error !== 1'b0 || mem_gnt !== 1'b0) begin
      errors++; $display("FAIL read_rsp got recv=%b d=%h e=%b g=%b exp 1 deadbeef 0 0",
        mem_recv, mem_rdata, mem_error, mem_gnt);
    end
    m_rvalid = 1'b0; m_arready = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_recv !== 1'b0 || mem_gnt !== 1'b1 || ar_hs - ar0 !== 1) begin
      errors++; $display("FAIL read_done got recv=%b g=%b ar=%0d exp 0 1 1", mem_recv, mem_gnt, ar_hs - ar0);
    end
  endtask

  task automatic test_write_w_late();
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h4000_0020;
    mem_wdata = 32'h1234_5678; mem_strb = 4'b0011;
    m_awready = 1'b1; m_wready = 1'b0;
    step(); // N
    mem_req = 1'b0; mem_wen = 1'b0;
    checks++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 32'h0000_0020 ||
        m_wdata !== 32'h1234_5678 || m_wstrb !== 4'b0011) begin
      errors++; $display("FAIL wr_issue got awv=%b wv=%b a=%h d=%h s=%b exp 1 1 00000020 12345678 0011",
        m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1 || m_bready !== 1'b0 || m_wdata !== 32'h1234_5678) begin
        errors++; $display("FAIL wr_wait%0d got awv=%b wv=%b br=%b d=%h exp 0 1 0 12345678",
          i, m_awvalid, m_wvalid, m_bready, m_wdata);
      end
    end
    m_awready = 1'b0; m_wready = 1'b1;
    step();
    m_wready = 1'b0;
    checks++;
    if (m_wvalid !== 1'b0 || m_bready !== 1'b1) begin
      errors++; $display("FAIL wr_bready got wv=%b br=%b exp 0 1", m_wvalid, m_bready);
    end
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step();
    m_bvalid = 1'b0;
    checks++;
    if (mem_recv !== 1'b1 || mem_rdata !== 32'h0 || mem_error !== 1'b0 || m_bready !== 1'b0) begin
      errors++; $display("FAIL wr_rsp got recv=%b d=%h e=%b br=%b exp 1 0 0 0", mem_recv, mem_rdata, mem_error, m_bready);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_read_error_hold();
    int ar0;
    ar0 = ar_hs;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h4000_0100;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55AA_55AA; m_rresp = 2'b10;
    repeat (3) step();
    m_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem_recv !== 1'b1 || mem_error !== 1'b1 || mem_rdata !== 32'h55AA_55AA || m_arvalid !== 1'b0) begin
        errors++; $display("FAIL rderr_hold%0d got recv=%b e=%b d=%h arv=%b exp 1 1 55aa55aa 0",
          i, mem_recv, mem_error, mem_rdata, m_arvalid);
      end
      if (i < 5) step();
    end
    mem_req = 1'b0; mem_ack = 1'b1; m_arready = 1'b0;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_recv !== 1'b0 || mem_gnt !== 1'b1 || ar_hs - ar0 !== 1) begin
      errors++; $display("FAIL rderr_done got recv=%b g=%b ar=%0d exp 0 1 1", mem_recv, mem_gnt, ar_hs - ar0);
    end
  endtask

  task automatic test_reset_mid();
    int ar0;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h4000_0040; m_arready = 1'b0;
    step();
    mem_req = 1'b0;
    checks++;
    if (m_arvalid !== 1'b1 || mem_rdata !== 32'h55AA_55AA) begin
      errors++; $display("FAIL rstmid_pre got arv=%b d=%h exp 1 55aa55aa", m_arvalid, mem_rdata);
    end
    #2 g_resetn = 1'b0;
    #1;
    checks++;
    if (m_arvalid !== 1'b0 || mem_recv !== 1'b0 || mem_rdata !== 32'h0 || mem_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_async got arv=%b recv=%b d=%h g=%b exp 0 0 0 1",
        m_arvalid, mem_recv, mem_rdata, mem_gnt);
    end
    @(negedge g_clk) g_resetn = 1'b1;
    step();
    ar0 = ar_hs;
    mem_req = 1'b1; mem_addr = 32'h4ABC_DEF0;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b01;
    step();
    mem_req = 1'b0;
    checks++;
    if (m_araddr !== 32'h0ABC_DEF0) begin
      errors++; $display("FAIL rstmid_addr got %h exp 0abcdef0", m_araddr);
    end
    repeat (2) step();
    m_rvalid = 1'b0; m_arready = 1'b0;
    checks++;
    if (mem_recv !== 1'b1 || mem_rdata !== 32'hCAFE_F00D || mem_error !== 1'b0 || ar_hs - ar0 !== 1) begin
      errors++; $display("FAIL rstmid_read got recv=%b d=%h e=%b ar=%0d exp 1 cafef00d 0 1",
        mem_recv, mem_rdata, mem_error, ar_hs - ar0);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_write_same_cycle();
    int aw0, w0;
    aw0 = aw_hs; w0 = w_hs;
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h4000_0080;
    mem_wdata = 32'hA5A5_0F0F; mem_strb = 4'b1111;
    m_awready = 1'b1; m_wready = 1'b1;
    step();
    mem_req = 1'b0; mem_wen = 1'b0;
    mem_ack = 1'b1; // ack outside RSP must be ignored
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_bready !== 1'b1 || mem_recv !== 1'b0 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
        errors++; $display("FAIL wrb_wait%0d got br=%b recv=%b awv=%b wv=%b exp 1 0 0 0",
          i, m_bready, mem_recv, m_awvalid, m_wvalid);
      end
      step();
    end
    m_bvalid = 1'b1; m_bresp = 2'b11;
    step();
    m_bvalid = 1'b0;
    checks++;
    if (mem_recv !== 1'b1 || mem_error !== 1'b1 || mem_rdata !== 32'h0 ||
        aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
      errors++; $display("FAIL wrb_rsp got recv=%b e=%b d=%h aw=%0d w=%0d exp 1 1 0 1 1",
        mem_recv, mem_error, mem_rdata, aw_hs - aw0, w_hs - w0);
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_recv !== 1'b0 || mem_gnt !== 1'b1) begin
      errors++; $display("FAIL wrb_done got recv=%b g=%b exp 0 1", mem_recv, mem_gnt);
    end
  endtask

  task automatic test_align();
    int ar0;
    ar0 = ar_hs;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h4000_0002;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; m_rresp = 2'b00;
    step();
    mem_req = 1'b0;
`ifdef IC_AXI_BRIDGE_ALIGN_CHECK_EN
    checks++;
    if (mem_recv !== 1'b1 || mem_error !== 1'b1 || mem_rdata !== 32'h0 || m_arvalid !== 1'b0) begin
      errors++; $display("FAIL align_rsp got recv=%b e=%b d=%h arv=%b exp 1 1 0 0",
        mem_recv, mem_error, mem_rdata, m_arvalid);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0;
    step();
    checks++;
    if (ar_hs - ar0 !== 0 || m_arvalid !== 1'b0 || mem_gnt !== 1'b1) begin
      errors++; $display("FAIL align_noaxi got ar=%0d arv=%b g=%b exp 0 0 1", ar_hs - ar0, m_arvalid, mem_gnt);
    end
`else
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_0002) begin
      errors++; $display("FAIL align_ar got arv=%b a=%h exp 1 00000002", m_arvalid, m_araddr);
    end
    repeat (2) step();
    m_arready = 1'b0; m_rvalid = 1'b0;
    checks++;
    if (mem_recv !== 1'b1 || mem_rdata !== 32'h0BAD_F00D || mem_error !== 1'b0 || ar_hs - ar0 !== 1) begin
      errors++; $display("FAIL align_read got recv=%b d=%h e=%b ar=%0d exp 1 0badf00d 0 1",
        mem_recv, mem_rdata, mem_error, ar_hs - ar0);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_w_late();
    test_read_error_hold();
    test_reset_mid();
    test_write_same_cycle();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
